// File: rtl/calc_pkg.sv
// Shared key-code constants, operator encoding and FSM state enumeration for the
// calculator key-entry block.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_A0,
        ST_A1,
        ST_A2,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_ISSUE
    } state_t;

    typedef enum logic [1:0] {
        KC_DIGIT,
        KC_OP,
        KC_EQ,
        KC_CLR
    } key_class_t;

    function automatic key_class_t classify(input logic [3:0] code);
        if (code <= 4'd9)
            return KC_DIGIT;
        else if (code == KEY_EQ)
            return KC_EQ;
        else if (code == KEY_CLR)
            return KC_CLR;
        else
            return KC_OP;
    endfunction

    // Operator keys 10..13 map directly onto op codes 0..3.
    function automatic logic [1:0] key_to_op(input logic [3:0] code);
        logic [3:0] d;
        d = code - KEY_ADD;
        return d[1:0];
    endfunction

endpackage

// File: rtl/calc_digit_shift.sv
// Two-digit BCD shift register: load shifts ones into tens and takes a new ones
// digit; clear zeroes both, and clear+load together leaves just the new digit.
module calc_digit_shift (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [3:0] i_digit,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (i_load) begin
            r_tens <= i_clr ? 4'd0 : r_ones;
            r_ones <= i_digit;
        end else if (i_clr) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end
    end

    assign o_tens = r_tens;
    assign o_ones = r_ones;

endmodule

// File: rtl/calc_key_entry.sv
// Calculator key-entry FSM: collects two 2-digit BCD operands and an operator,
// then offers them downstream with a valid/ready handshake.
// Optional macro CALC_KEY_DIVZERO_EN rejects "equal" on a divide by zero.
import calc_pkg::*;

module calc_key_entry (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [3:0] v11,
    output logic [3:0] v12,
    output logic [3:0] v21,
    output logic [3:0] v22,
    output logic [1:0] op,
    output logic       calc_valid,
    input  logic       calc_ready,
    output logic       err
);

    state_t     r_state;
    logic [1:0] r_op;
    logic       r_err;
    logic       r_calc_valid;
    logic       r_key_ready;

    logic       w_accept;
    key_class_t w_class;
    logic       w_op1_clr;
    logic       w_op1_ld;
    logic       w_op2_clr;
    logic       w_op2_ld;
    logic       w_div_zero;
    logic [3:0] w_v11;
    logic [3:0] w_v12;
    logic [3:0] w_v21;
    logic [3:0] w_v22;

    assign w_accept = key_valid & r_key_ready;
    assign w_class  = classify(key_code);

`ifdef CALC_KEY_DIVZERO_EN
    assign w_div_zero = (r_op == OP_DIV) && (w_v21 == 4'd0) && (w_v22 == 4'd0);
`else
    assign w_div_zero = 1'b0;
`endif

    // Operand register strobes; a first digit in A0 wipes both operands.
    always_comb begin
        w_op1_clr = 1'b0;
        w_op1_ld  = 1'b0;
        w_op2_clr = 1'b0;
        w_op2_ld  = 1'b0;
        if (w_accept) begin
            case (w_class)
                KC_DIGIT: begin
                    case (r_state)
                        ST_A0: begin
                            w_op1_clr = 1'b1;
                            w_op1_ld  = 1'b1;
                            w_op2_clr = 1'b1;
                        end
                        ST_A1:        w_op1_ld = 1'b1;
                        ST_B0, ST_B1: w_op2_ld = 1'b1;
                        default:      ;
                    endcase
                end
                KC_CLR: begin
                    w_op1_clr = 1'b1;
                    w_op2_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    calc_digit_shift u_op1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_op1_clr),
        .i_load  (w_op1_ld),
        .i_digit (key_code),
        .o_tens  (w_v11),
        .o_ones  (w_v12)
    );

    calc_digit_shift u_op2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_op2_clr),
        .i_load  (w_op2_ld),
        .i_digit (key_code),
        .o_tens  (w_v21),
        .o_ones  (w_v22)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_A0;
            r_op         <= OP_ADD;
            r_err        <= 1'b0;
            r_calc_valid <= 1'b0;
            r_key_ready  <= 1'b1;
        end else if (r_state == ST_ISSUE) begin
            if (calc_ready) begin
                r_state      <= ST_A0;
                r_calc_valid <= 1'b0;
                r_key_ready  <= 1'b1;
            end
        end else if (w_accept) begin
            case (w_class)
                KC_DIGIT: begin
                    case (r_state)
                        ST_A0: begin
                            r_op    <= OP_ADD;
                            r_state <= ST_A1;
                        end
                        ST_A1:        r_state <= ST_A2;
                        ST_B0:        r_state <= ST_B1;
                        ST_B1:        r_state <= ST_B2;
                        ST_A2, ST_B2: r_err   <= 1'b1;
                        default:      ;
                    endcase
                end
                KC_OP: begin
                    case (r_state)
                        ST_A1, ST_A2: begin
                            r_op    <= key_to_op(key_code);
                            r_state <= ST_B0;
                        end
                        ST_B0:   r_op  <= key_to_op(key_code);
                        default: r_err <= 1'b1;
                    endcase
                end
                KC_EQ: begin
                    if ((r_state == ST_B1 || r_state == ST_B2) && !w_div_zero) begin
                        r_state      <= ST_ISSUE;
                        r_calc_valid <= 1'b1;
                        r_key_ready  <= 1'b0;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                KC_CLR: begin
                    r_state <= ST_A0;
                    r_op    <= OP_ADD;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign key_ready  = r_key_ready;
    assign calc_valid = r_calc_valid;
    assign op         = r_op;
    assign err        = r_err;
    assign v11        = w_v11;
    assign v12        = w_v12;
    assign v21        = w_v21;
    assign v22        = w_v22;

endmodule
